// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serial transmitter for a 4-bit nibble framed as
// start(0), d0..d3 (LSB first), odd parity, stop(1) on a line that idles high.
// Each serial bit is held for CLKS_PER_BIT clock cycles.
// Optional build macro PARITY_TX_STOP2_EN adds a second stop bit (8-bit frame).
// Every output comes from a flop; the next-state logic also computes the
// next output values so that in_valid and datain never reach an output
// combinationally.

module parity_frame_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] datain,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    // Bit-time counter runs 0..CLKS_PER_BIT-1 and is cleared at each bit boundary
    localparam int              CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef PARITY_TX_STOP2_EN
        , STOP2
`endif
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [1:0]      bit_idx;
    logic [1:0]      bit_idx_n;
    logic [3:0]      shift_reg;
    logic [3:0]      shift_n;
    logic            parity;
    logic            parity_n;
    logic            txd_n;
    logic            busy_n;
    logic            in_ready_n;
    logic            frame_done_n;
    logic            bit_end;
    logic            accept;

    // in_ready is itself a flop, so a handshake can never happen while held in reset
    assign accept  = in_valid && in_ready;
    assign bit_end = (cnt == LAST_CNT);

    // Next-state logic plus the values the output flops take on the next edge
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        bit_idx_n    = bit_idx;
        shift_n      = shift_reg;
        parity_n     = parity;
        frame_done_n = 1'b0;

        case (state)
            IDLE: begin
                cnt_n     = '0;
                bit_idx_n = 2'd0;
                if (accept) begin
                    shift_n  = datain;
                    parity_n = ~^datain;
                    state_n  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    shift_n = {1'b0, shift_reg[3:1]};
                    if (bit_idx == 2'd3) begin
                        state_n = PARITY;
                    end else begin
                        bit_idx_n = bit_idx + 2'd1;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
`ifdef PARITY_TX_STOP2_EN
                    state_n = STOP2;
`else
                    state_n      = IDLE;
                    frame_done_n = 1'b1;
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef PARITY_TX_STOP2_EN
            STOP2: begin
                if (bit_end) begin
                    cnt_n        = '0;
                    state_n      = IDLE;
                    frame_done_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase

        // Line level for the state being entered, so txd changes exactly at bit boundaries
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_n[0];
            PARITY:  txd_n = parity_n;
            default: txd_n = 1'b1;
        endcase

        busy_n     = (state_n != IDLE);
        in_ready_n = (state_n == IDLE);
    end

    // State, datapath and output flops; reset parks the line high and aborts any frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= 2'd0;
            shift_reg  <= 4'd0;
            parity     <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift_reg  <= shift_n;
            parity     <= parity_n;
            txd        <= txd_n;
            busy       <= busy_n;
            in_ready   <= in_ready_n;
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx: bench for parity_frame_tx.
// A frame-level model (bit array indexed by elapsed cycles / bit time) predicts
// txd, busy, in_ready and frame_done every cycle; directed frames are also
// compared against hand-written bit patterns.
// Honours PARITY_TX_STOP2_EN the same way the design does.

module tb_parity_frame_tx;

    localparam int C = 4;
`ifdef PARITY_TX_STOP2_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] datain;
    logic       in_valid;
    logic       in_ready;
    logic       txd;
    logic       busy;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Frame-level reference model state
    logic       m_busy;
    logic       m_ready;
    logic       m_done;
    int         m_t;
    logic [7:0] m_frame;

    parity_frame_tx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .datain     (datain),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .txd        (txd),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never finishes
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Frame bits in transmission order: start, d0..d3, odd parity, stop(s)
    function automatic logic [7:0] build_frame(input logic [3:0] d);
        logic [7:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(d[i]);
        f[0] = 1'b0;
        for (int i = 0; i < 4; i++) f[1+i] = d[i];
        f[5] = ((ones % 2) == 0);
        f[6] = 1'b1;
        f[7] = 1'b1;
        return f;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame lasts NB*C cycles after the accept edge, then one done cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b0;
            m_done  <= 1'b0;
            m_t     <= 0;
        end else if (m_busy) begin
            if (m_t == NB*C - 1) begin
                m_busy  <= 1'b0;
                m_ready <= 1'b1;
                m_done  <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end else begin
            m_done <= 1'b0;
            if (in_valid && m_ready) begin
                m_frame <= build_frame(datain);
                m_t     <= 0;
                m_busy  <= 1'b1;
                m_ready <= 1'b0;
            end else begin
                m_ready <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_txd",        32'(txd),        32'(m_busy ? m_frame[m_t / C] : 1'b1));
            checkOutput("cyc_busy",       32'(busy),       32'(m_busy));
            checkOutput("cyc_in_ready",   32'(in_ready),   32'(m_ready));
            checkOutput("cyc_frame_done", 32'(frame_done), 32'(m_done));
        end
    end

    // Send one nibble (called at a negedge with the DUT ready) and capture the frame
    task automatic applyStimulus(input logic [3:0] d, input logic [6:0] lit,
                                 input bit keep_valid, input bit corrupt, input string name);
        logic [7:0] got;
        logic [7:0] exp8;
        int         done_at;
        int         done_cnt;
        bit         ready_seen;
        got        = 8'd0;
        done_at    = 0;
        done_cnt   = 0;
        ready_seen = 1'b0;
        exp8       = {(NB == 8), lit};
        datain     = d;
        in_valid   = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= NB*C + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1 && !keep_valid) in_valid = 1'b0;
            if (corrupt && cyc == 2*C + 1) datain = 4'b1111;
            if (cyc <= NB*C && ((cyc - 1) % C) == 0) got[(cyc - 1) / C] = txd;
            if (cyc <= NB*C && in_ready) ready_seen = 1'b1;
            if (frame_done) begin
                done_cnt++;
                if (done_at == 0) done_at = cyc;
            end
        end
        checkOutput({name, "_bits"},       32'(got),        32'(exp8));
        checkOutput({name, "_done_cycle"}, 32'(done_at),    32'(NB*C + 1));
        checkOutput({name, "_done_count"}, 32'(done_cnt),   32'd1);
        checkOutput({name, "_ready_low"},  32'(ready_seen), 32'd0);
        checkOutput({name, "_idle_txd"},   32'(txd),        32'd1);
        checkOutput({name, "_end_ready"},  32'(in_ready),   32'd1);
    endtask

    initial begin
        logic [7:0] f;

        // Pin the model against hand-derived frames
        f = build_frame(4'b1010);
        checkOutput("model_frame_1010", 32'(f[6:0]), 32'(7'b1110100));
        f = build_frame(4'b0111);
        checkOutput("model_frame_0111", 32'(f[6:0]), 32'(7'b1001110));

        // Reset with in_valid already high
        rst_n    = 1'b0;
        in_valid = 1'b1;
        datain   = 4'b1010;
        #1;
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_txd",      32'(txd),      32'd1);
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_no_accept", 32'(busy),     32'd0);
        checkOutput("release_ready",     32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);

        $display("[TB] directed frames");
        applyStimulus(4'b1010, 7'b1110100, 1'b0, 1'b0, "f1010");
        applyStimulus(4'b0111, 7'b1001110, 1'b1, 1'b0, "b2b_0111");
        applyStimulus(4'b0000, 7'b1100000, 1'b0, 1'b0, "b2b_0000");
        applyStimulus(4'b0001, 7'b1000010, 1'b0, 1'b1, "mid_change_0001");

        $display("[TB] reset during data bits");
        datain   = 4'b0110;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2*C) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_txd",  32'(txd),        32'd1);
        checkOutput("async_rst_busy", 32'(busy),       32'd0);
        checkOutput("async_rst_done", 32'(frame_done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after_rst_ready", 32'(in_ready), 32'd1);
        applyStimulus(4'b1010, 7'b1110100, 1'b0, 1'b0, "post_rst_1010");

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 2) != 0);
            datain   = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (NB*C + 3) @(negedge clk);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serial frame transmitter that sits directly downstream of the odd-parity generator stage. It accepts a 4-bit nibble through a valid/ready handshake, computes its odd-parity bit internally, and serialises a start bit, four data bits (LSB first), the parity bit and a stop bit onto a single line. The frame format matches what the odd-parity check stage consumes: four data bits plus one parity bit, so that the XOR over all five bits equals 1.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles each serial bit is held; legal range 1..65535.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- datain, input, 4: nibble to transmit; sampled only on an accepted handshake.
- in_valid, input, 1: upstream has a nibble on datain.
- in_ready, output, 1: block can accept a nibble this cycle.
- txd, output, 1: serial line; idles high.
- busy, output, 1: a frame is being transmitted.
- frame_done, output, 1: one-cycle pulse when a frame completes.

## Operation
- Reset values: txd=1, in_ready=0 while rst_n=0 (1 from first clock edge after release), busy=0, frame_done=0, state=IDLE, counters=0.
- FSM states: IDLE, START, DATA, PARITY, STOP (plus STOP2 when configured).
- IDLE: in_ready=1, txd=1, busy=0. Accept occurs when in_valid && in_ready at a rising edge. On accept:
  - Latch datain into a shift register.
  - Latch parity = ~^datain.
  - Move to START.
- START: txd=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: txd = shift_reg[0]. Hold each bit CLKS_PER_BIT cycles, then shift right. After bit index 3 completes, go to PARITY.
- PARITY: txd = latched parity for CLKS_PER_BIT cycles, then STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. Then return to IDLE and pulse frame_done for exactly that one cycle.
- Outside IDLE: in_ready=0, busy=1. in_valid and datain are ignored; a change on datain mid-frame does not alter txd.
- Bit-time counter width is $clog2(CLKS_PER_BIT+1). It resets to 0 at every bit boundary and never wraps inside a bit.
- All outputs are registered; no combinational path from in_valid or datain to any output.

## Timing
- Accept at edge T: busy=1, in_ready=0, txd=0 from T+1.
- Bit k of the frame (k=0 start .. 6 stop) occupies cycles T+1+k*CLKS_PER_BIT through T+(k+1)*CLKS_PER_BIT.
- Frame length: 7*CLKS_PER_BIT cycles (8*CLKS_PER_BIT with STOP2).
- At edge T+7*CLKS_PER_BIT+1 the block returns to IDLE: frame_done=1, in_ready=1, busy=0, txd=1.
- Back-to-back: if in_valid is held high, the next accept occurs on the edge ending the frame_done cycle. That gives exactly one idle-high cycle between frames.
- CLKS_PER_BIT=1: each bit lasts one cycle; frame is 7 cycles.
- Reset mid-frame: txd forced to 1 and busy to 0 immediately (asynchronous). The frame is aborted, with no frame_done. in_ready rises on the first edge after release.
- Reset released on the same edge as in_valid=1: no accept on that edge, because in_ready is still 0.

## Configuration
- PARITY_TX_STOP2_EN defined: a STOP2 state follows STOP. txd stays 1 for a second bit time, giving an 8-bit frame. frame_done pulses after STOP2.
- Not defined: single stop bit and a 7-bit frame; STOP2 logic is absent.

## Test plan
- Reset then idle: rst_n low 3 cycles, then high. Required: txd=1, busy=0 and frame_done=0 throughout; in_ready=1 from the first edge after release.
- datain=4'b1010, CLKS_PER_BIT=4. Required txd per bit time: 0,0,1,0,1,1,1 (parity 1). frame_done pulses once, 28 cycles after accept plus 1.
- datain=4'b0111, then 4'b0000, back-to-back with in_valid held high. Required: first frame 0,1,1,1,0,0,1 (parity 0); exactly one idle cycle; second frame 0,0,0,0,0,1,1 (parity 1).
- datain changed to 4'b1111 mid-frame after accepting 4'b0001. Required: transmitted bits remain 0,1,0,0,0,0,1; in_ready stays 0 until frame end.
- rst_n pulsed low during the DATA state. Required: txd=1 and busy=0 asynchronously, no frame_done, and a clean next frame after release.
- PARITY_TX_STOP2_EN defined with CLKS_PER_BIT=1 and datain=4'b1010. Required txd: 0,0,1,0,1,1,1,1. frame_done occurs on cycle 9 after accept.
